// File: rtl/poly_regfile_sb.sv
`default_nettype none
// ============================================================================
// Module   : poly_regfile_sb
// Purpose  : Scoreboarded polynomial register file. Each of NREAD read ports
//            and NWRITE write ports moves one full RNS polynomial vector
//            (ELEMS residues of WIDTH bits) per cycle. After reset the file
//            zero-clears itself one register per cycle. Reads are registered
//            with same-cycle write bypass. Per-register busy bits refuse reads
//            of destinations that are still in flight.
// Ports    : clk, reset         - clock, asynchronous active-high reset
//            ready_o            - clear sequence finished
//            rsv_valid_i/idx_i  - mark a destination register busy
//            rd_req_i/idx_i     - per-port read request and source index
//            rd_valid_o/busy_o  - read accepted / refused (busy source)
//            rd_data_o          - registered read data (held when not valid)
//            wr_valid_i/idx_i/data_i - per-port writeback
//            wr_conflict_o      - two write ports hit the same register
// Revision : 1.0 - initial release
// ============================================================================
module poly_regfile_sb #(
  parameter int NREG   = 8,
  parameter int NREAD  = 4,
  parameter int NWRITE = 2,
  parameter int ELEMS  = 8,
  parameter int WIDTH  = 32,
  parameter int IW     = $clog2(NREG)
) (
  input  logic                            clk,
  input  logic                            reset,
  output logic                            ready_o,
  input  logic                            rsv_valid_i,
  input  logic [IW-1:0]                   rsv_idx_i,
  input  logic [NREAD-1:0]                rd_req_i,
  input  logic [NREAD*IW-1:0]             rd_idx_i,
  output logic [NREAD-1:0]                rd_valid_o,
  output logic [NREAD-1:0]                rd_busy_o,
  output logic [NREAD*ELEMS*WIDTH-1:0]    rd_data_o,
  input  logic [NWRITE-1:0]               wr_valid_i,
  input  logic [NWRITE*IW-1:0]            wr_idx_i,
  input  logic [NWRITE*ELEMS*WIDTH-1:0]   wr_data_i,
  output logic                            wr_conflict_o
);

  localparam int c_pw = ELEMS * WIDTH;

  typedef enum logic [0:0] {
    S_CLEAR = 1'b0,
    S_RUN   = 1'b1
  } state_t;

  state_t                      state_q, state_d;
  logic [IW-1:0]               clr_cnt_q, clr_cnt_d;
  logic                        ready_q;
  logic [NREG-1:0]             busy_q, busy_d;
  logic [c_pw-1:0]             mem_q [NREG];

  logic [NREAD-1:0]            rd_valid_q, rd_valid_d;
  logic [NREAD-1:0]            rd_busy_q, rd_busy_d;
  logic [NREAD*c_pw-1:0]       rd_data_q, rd_data_d;
  logic                        conflict_q;

  // Per-register winning write of this cycle (highest port number wins)
  logic [NREG-1:0]             win_valid_w;
  logic [c_pw-1:0]             win_data_w [NREG];
  logic                        conflict_w;

  always_comb begin
    win_valid_w = '0;
    conflict_w  = 1'b0;
    for (int r = 0; r < NREG; r++) begin
      win_data_w[r] = '0;
    end
    // Ascending port order: a later port overwrites an earlier one.
    for (int p = 0; p < NWRITE; p++) begin
      if (wr_valid_i[p]) begin
        win_valid_w[wr_idx_i[p*IW +: IW]] = 1'b1;
        win_data_w[wr_idx_i[p*IW +: IW]]  = wr_data_i[p*c_pw +: c_pw];
      end
    end
    for (int p = 1; p < NWRITE; p++) begin
      for (int q = 0; q < p; q++) begin
        if (wr_valid_i[p] && wr_valid_i[q] &&
            (wr_idx_i[p*IW +: IW] == wr_idx_i[q*IW +: IW])) begin
          conflict_w = 1'b1;
        end
      end
    end
  end

  // Control FSM and busy scoreboard next state
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    busy_d    = busy_q;
    case (state_q)
      S_CLEAR: begin
        busy_d = '0;
        if (clr_cnt_q == IW'(NREG - 1)) begin
          state_d   = S_RUN;
          clr_cnt_d = '0;
        end else begin
          clr_cnt_d = clr_cnt_q + 1'b1;
        end
      end
      S_RUN: begin
        busy_d = busy_q & ~win_valid_w;
        // Applied after the write clear: the reservation belongs to the
        // newer operation and must survive a same-cycle writeback.
        if (rsv_valid_i) begin
          busy_d[rsv_idx_i] = 1'b1;
        end
      end
      default: begin
        state_d   = S_CLEAR;
        clr_cnt_d = '0;
      end
    endcase
  end

  // Read resolution against current state with same-cycle writes applied;
  // busy is checked before this cycle's reservation takes effect.
  always_comb begin
    rd_valid_d = '0;
    rd_busy_d  = '0;
    rd_data_d  = rd_data_q;
    if (state_q == S_RUN) begin
      for (int k = 0; k < NREAD; k++) begin
        if (rd_req_i[k]) begin
          if (win_valid_w[rd_idx_i[k*IW +: IW]]) begin
            rd_valid_d[k]               = 1'b1;
            rd_data_d[k*c_pw +: c_pw]   = win_data_w[rd_idx_i[k*IW +: IW]];
          end else if (busy_q[rd_idx_i[k*IW +: IW]]) begin
            rd_busy_d[k]                = 1'b1;
          end else begin
            rd_valid_d[k]               = 1'b1;
            rd_data_d[k*c_pw +: c_pw]   = mem_q[rd_idx_i[k*IW +: IW]];
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_CLEAR;
      clr_cnt_q  <= '0;
      ready_q    <= 1'b0;
      busy_q     <= '0;
      rd_valid_q <= '0;
      rd_busy_q  <= '0;
      rd_data_q  <= '0;
      conflict_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_cnt_q  <= clr_cnt_d;
      ready_q    <= (state_d == S_RUN);
      busy_q     <= busy_d;
      rd_valid_q <= rd_valid_d;
      rd_busy_q  <= rd_busy_d;
      rd_data_q  <= rd_data_d;
      conflict_q <= (state_q == S_RUN) && conflict_w;
    end
  end

  // Storage has no reset; the CLEAR sequence zeroes it instead.
  always_ff @(posedge clk) begin
    if (state_q == S_CLEAR) begin
      mem_q[clr_cnt_q] <= '0;
    end else begin
      for (int r = 0; r < NREG; r++) begin
        if (win_valid_w[r]) begin
          mem_q[r] <= win_data_w[r];
        end
      end
    end
  end

  assign ready_o       = ready_q;
  assign rd_valid_o    = rd_valid_q;
  assign rd_busy_o     = rd_busy_q;
  assign rd_data_o     = rd_data_q;
  assign wr_conflict_o = conflict_q;

endmodule
`default_nettype wire

// File: tb/tb_poly_regfile_sb.sv
`default_nettype none
// ============================================================================
// Module   : tb_poly_regfile_sb
// Purpose  : Directed self-checking bench for poly_regfile_sb with
//            hand-computed expected vectors.
// Revision : 1.0 - initial release
// ============================================================================
module tb_poly_regfile_sb;

  localparam int NREG = 8, NREAD = 4, NWRITE = 2, ELEMS = 8, WIDTH = 32, IW = 3;
  localparam int PW = ELEMS * WIDTH;

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   ready;
  logic                   rsv_valid;
  logic [IW-1:0]          rsv_idx;
  logic [NREAD-1:0]       rd_req;
  logic [NREAD*IW-1:0]    rd_idx;
  logic [NREAD-1:0]       rd_valid;
  logic [NREAD-1:0]       rd_busy;
  logic [NREAD*PW-1:0]    rd_data;
  logic [NWRITE-1:0]      wr_valid;
  logic [NWRITE*IW-1:0]   wr_idx;
  logic [NWRITE*PW-1:0]   wr_data;
  logic                   wr_conflict;

  int n_total = 0;
  int n_bad   = 0;

  poly_regfile_sb #(
    .NREG(NREG), .NREAD(NREAD), .NWRITE(NWRITE),
    .ELEMS(ELEMS), .WIDTH(WIDTH), .IW(IW)
  ) u_dut (
    .clk          (clk),
    .reset        (reset),
    .ready_o      (ready),
    .rsv_valid_i  (rsv_valid),
    .rsv_idx_i    (rsv_idx),
    .rd_req_i     (rd_req),
    .rd_idx_i     (rd_idx),
    .rd_valid_o   (rd_valid),
    .rd_busy_o    (rd_busy),
    .rd_data_o    (rd_data),
    .wr_valid_i   (wr_valid),
    .wr_idx_i     (wr_idx),
    .wr_data_i    (wr_data),
    .wr_conflict_o(wr_conflict)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [PW-1:0] got, input logic [PW-1:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Every element equal to v
  function automatic logic [PW-1:0] rep(input logic [WIDTH-1:0] v);
    logic [PW-1:0] r;
    for (int e = 0; e < ELEMS; e++) r[e*WIDTH +: WIDTH] = v;
    return r;
  endfunction

  // Element e equal to base+e
  function automatic logic [PW-1:0] seqv(input logic [WIDTH-1:0] base);
    logic [PW-1:0] r;
    for (int e = 0; e < ELEMS; e++) r[e*WIDTH +: WIDTH] = base + WIDTH'(e);
    return r;
  endfunction

  function automatic logic [PW-1:0] rdat(input int k);
    return rd_data[k*PW +: PW];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rsv_valid = 1'b0; rsv_idx = '0;
    rd_req = '0; rd_idx = '0;
    wr_valid = '0; wr_idx = '0; wr_data = '0;
  endtask

  task automatic rd(input int k, input int r);
    rd_req[k] = 1'b1;
    rd_idx[k*IW +: IW] = IW'(r);
  endtask

  task automatic wr(input int p, input int r, input logic [PW-1:0] d);
    wr_valid[p] = 1'b1;
    wr_idx[p*IW +: IW] = IW'(r);
    wr_data[p*PW +: PW] = d;
  endtask

  task automatic clear_phase(input string tag);
    for (int i = 1; i <= NREG; i++) begin
      // Traffic during CLEAR must be ignored entirely
      idle();
      rd(0, 1);
      wr(1, 7, rep(32'hDEAD_BEEF));
      rsv_valid = 1'b1; rsv_idx = 3'd1;
      step();
      chk({tag, "_ready"}, PW'(ready), PW'(i == NREG));
      chk({tag, "_clr_rdv"}, PW'(rd_valid | rd_busy), PW'(0));
    end
    idle();
  endtask

  initial begin
    idle();
    reset = 1'b1;
    step(); step();
    chk("rst_ready", PW'(ready), PW'(0));
    chk("rst_rdv", PW'({rd_valid, rd_busy, wr_conflict}), PW'(0));
    chk("rst_data", rd_data[PW-1:0], PW'(0));
    reset = 1'b0;
    clear_phase("clr1");

    // All registers read zero, not busy
    rd(0, 0); rd(1, 1); rd(2, 2); rd(3, 3);
    step(); idle();
    chk("zero_v_lo", PW'(rd_valid), PW'(4'hF));
    for (int k = 0; k < NREAD; k++) chk("zero_d_lo", rdat(k), PW'(0));
    rd(0, 4); rd(1, 5); rd(2, 6); rd(3, 7);
    step(); idle();
    chk("zero_v_hi", PW'(rd_valid), PW'(4'hF));
    for (int k = 0; k < NREAD; k++) chk("zero_d_hi", rdat(k), PW'(0));

    // Write reg3, read next cycle on port 2
    wr(0, 3, seqv(32'h11));
    step(); idle();
    rd(2, 3);
    step(); idle();
    chk("w3_valid", PW'(rd_valid), PW'(4'b0100));
    chk("w3_data", rdat(2), seqv(32'h11));
    chk("w3_hold0", rdat(0), PW'(0));

    // All ports read reg3 together
    rd(0, 3); rd(1, 3); rd(2, 3); rd(3, 3);
    step(); idle();
    chk("multi_v", PW'(rd_valid), PW'(4'hF));
    for (int k = 0; k < NREAD; k++) chk("multi_d", rdat(k), seqv(32'h11));

    // Reserve reg5, then read refused
    rsv_valid = 1'b1; rsv_idx = 3'd5;
    step(); idle();
    rd(0, 5);
    step(); idle();
    chk("busy_b", PW'(rd_busy), PW'(4'b0001));
    chk("busy_v", PW'(rd_valid), PW'(0));
    chk("busy_hold", rdat(0), seqv(32'h11));
    // Write reg5 with same-cycle read on port 1 -> bypass
    wr(0, 5, rep(32'hA5)); rd(1, 5);
    step(); idle();
    chk("byp_v", PW'(rd_valid), PW'(4'b0010));
    chk("byp_b", PW'(rd_busy), PW'(0));
    chk("byp_d", rdat(1), rep(32'hA5));
    rd(3, 5);
    step(); idle();
    chk("post_byp_v", PW'(rd_valid), PW'(4'b1000));
    chk("post_byp_d", rdat(3), rep(32'hA5));

    // Reservation does not affect same-cycle read; next read refused
    rsv_valid = 1'b1; rsv_idx = 3'd7; rd(2, 7);
    step(); idle();
    chk("rsv_same_v", PW'(rd_valid), PW'(4'b0100));
    rd(2, 7);
    step(); idle();
    chk("rsv_next_b", PW'(rd_busy), PW'(4'b0100));
    wr(1, 7, rep(32'h77));
    step(); idle();

    // Different-register writes: no conflict
    wr(0, 0, rep(32'h10)); wr(1, 1, rep(32'h20));
    step(); idle();
    chk("noconf", PW'(wr_conflict), PW'(0));

    // Both ports write reg2; port 1 wins, bypass sees winner
    wr(0, 2, rep(32'h1)); wr(1, 2, rep(32'h2)); rd(0, 2);
    step(); idle();
    chk("conf_pulse", PW'(wr_conflict), PW'(1));
    chk("conf_byp", rdat(0), rep(32'h2));
    rd(3, 2); rd(1, 0); rd(2, 1);
    step(); idle();
    chk("conf_end", PW'(wr_conflict), PW'(0));
    chk("conf_store", rdat(3), rep(32'h2));
    chk("w_p0_r0", rdat(1), rep(32'h10));
    chk("w_p1_r1", rdat(2), rep(32'h20));

    // Reserve and write reg6 same cycle: busy stays set
    rsv_valid = 1'b1; rsv_idx = 3'd6; wr(1, 6, rep(32'h66));
    step(); idle();
    rd(0, 6);
    step(); idle();
    chk("rw6_busy", PW'(rd_busy), PW'(4'b0001));
    chk("rw6_v", PW'(rd_valid), PW'(0));
    wr(0, 6, rep(32'h66));
    step(); idle();
    rd(2, 6);
    step(); idle();
    chk("rw6_v2", PW'(rd_valid), PW'(4'b0100));
    chk("rw6_d", rdat(2), rep(32'h66));

    // Reset mid-RUN with reg4 = 0x44 and busy
    wr(0, 4, rep(32'h44));
    step(); idle();
    rsv_valid = 1'b1; rsv_idx = 3'd4;
    step(); idle();
    rd(0, 4);
    step(); idle();
    chk("pre_rst_busy", PW'(rd_busy), PW'(4'b0001));
    reset = 1'b1;
    #1;
    chk("rst2_ready", PW'(ready), PW'(0));
    chk("rst2_busy", PW'(rd_busy), PW'(0));
    step();
    reset = 1'b0;
    clear_phase("clr2");
    rd(1, 4); rd(0, 7);
    step(); idle();
    chk("rst2_v", PW'(rd_valid), PW'(4'b0011));
    chk("rst2_d4", rdat(1), PW'(0));
    chk("rst2_d7", rdat(0), PW'(0));

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/poly_regfile_sb.md
# poly_regfile_sb

Parametrised, scoreboarded polynomial register file for the FHE datapath: NREAD read ports and NWRITE write ports, each moving one full RNS polynomial vector (ELEMS residues of WIDTH bits) per cycle. It adds a hardware zero-clear after reset, registered reads with write-to-read bypass, and per-register busy bits so functional units cannot read a destination that is still in flight. It sits between the CPU issue logic (reservations, read requests) and the FU writeback buses.

## Interface
Parameters:
- NREG, 8, number of polynomial registers (reg = cipher*NPOLY + poly)
- NREAD, 4, read ports
- NWRITE, 2, write ports
- ELEMS, 8, residues per polynomial (NCOEFF*NPRIMES, flat index c*NPRIMES+p)
- WIDTH, 32, bits per residue
- IW, $clog2(NREG), derived index width

Ports (port k occupies bits [k*IW +: IW] of index buses and [k*ELEMS*WIDTH +: ELEMS*WIDTH] of data buses; element e at [e*WIDTH +: WIDTH]):
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- ready  out  1  high once the clear sequence is done
- rsv_valid  in  1  reserve a destination register (mark busy)
- rsv_idx  in  IW  register to reserve
- rd_req  in  NREAD  per-port read request
- rd_idx  in  NREAD*IW  per-port source register
- rd_valid  out  NREAD  read data valid (one cycle after request)
- rd_busy  out  NREAD  request refused because source was busy
- rd_data  out  NREAD*ELEMS*WIDTH  read data
- wr_valid  in  NWRITE  per-port writeback strobe
- wr_idx  in  NWRITE*IW  per-port destination register
- wr_data  in  NWRITE*ELEMS*WIDTH  writeback data
- wr_conflict  out  1  one-cycle pulse: two write ports hit the same register

## Operation
- FSM states CLEAR and RUN. Reset (async) forces CLEAR, clear counter 0, all busy bits 0, all outputs 0 (ready, rd_valid, rd_busy, rd_data, wr_conflict).
- CLEAR: each cycle writes all-zero to register[counter], counter++; after writing NREG-1 go to RUN. rsv_valid, rd_req, wr_valid ignored (no effect, no response).
- RUN: ready=1. Reset mid-RUN or mid-CLEAR restarts CLEAR from register 0.
- Write: for each port with wr_valid, register[wr_idx] <= wr_data and busy[wr_idx] cleared. Same index on several ports: highest port number wins; wr_conflict=1 next cycle.
- Reserve: rsv_valid sets busy[rsv_idx]. Reserve and write to the same register in the same cycle: data written, busy ends 1 (reservation belongs to the newer op).
- Read: rd_req on port k in cycle t evaluates rd_idx against state at t with same-cycle writes applied: if a write in cycle t targets it, the read returns the winning write data and is not busy; else if busy, refused; else returns stored contents. Reservation in cycle t does not affect reads in cycle t.
- Accepted read: rd_valid[k]=1, rd_busy[k]=0, rd_data updated. Refused: rd_valid[k]=0, rd_busy[k]=1, rd_data[k] holds previous value. No request: both 0, data held. Requester retries on its own.
- Any number of ports may read the same register in one cycle.

## Timing
- Read latency 1 cycle (registered outputs); no pipeline stalls otherwise; full throughput on every port.
- Write visible to storage at the edge ending cycle t; bypassed to reads in t.
- ready rises after exactly NREG rising edges following reset deassertion.
- wr_conflict, rd_busy, rd_valid are single-cycle registered pulses per event.

## Test plan
- Reset, count edges -> ready=0 for 8 cycles, 1 on 9th; reads of all 8 registers then return all-zero with rd_valid=1.
- Write reg 3 = elements 0x11..0x18 on port 0, read reg 3 next cycle on port 2 -> rd_valid[2]=1, data 0x11..0x18.
- Reserve reg 5, read reg 5 -> rd_busy=1, rd_valid=0; write reg 5 = 0xA5 all elements while port 1 reads reg 5 same cycle -> next cycle rd_valid[1]=1, data 0xA5 (bypass).
- Ports 0 and 1 both write reg 2 (0x1 vs 0x2) -> wr_conflict pulses 1 cycle, reg 2 reads 0x2.
- Reserve and write reg 6 same cycle (0x66), then read reg 6 -> rd_busy=1; data 0x66 returned after a later write clears busy... (verify stored value 0x66 via write of same data).
- Assert reset during RUN with reg 4 busy and reg 4 = 0x44 -> ready drops immediately, busy cleared, after clear reg 4 reads 0.
